// File: rtl/custom_reg_to_axi_master_if.sv
// Single-beat AXI4 master/slave bundle used by custom_reg_to_axi_master.
interface custom_reg_to_axi_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/custom_reg_to_axi_master.sv
// Register-bus to single-beat AXI4 master bridge.
// Optional response watchdog with DRAIN state: define REG2AXI_TIMEOUT_EN.
module custom_reg_to_axi_master #(
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter int unsigned                AXI_DATA_WIDTH = 32,
    parameter int unsigned                AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int unsigned                AXI_ID_WIDTH   = 2,
    parameter int unsigned                AXI_ID         = 0,
    parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = {AXI_ADDR_WIDTH{1'b0}},
    parameter int unsigned                TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                          req_write_i,
    input  logic [AXI_DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [AXI_STRB_WIDTH-1:0]     req_wstrb_i,
    input  logic                          req_valid_i,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
    output logic                          rsp_error_o,
    output logic                          rsp_ready_o,
    output logic                          busy_o,
    custom_reg_to_axi_master_if.master    m_axi
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_RSP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_RSP = 3'd4,
        ST_RESP   = 3'd5
`ifdef REG2AXI_TIMEOUT_EN
        ,
        ST_DRAIN  = 3'd6
`endif
    } state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      is_write_q, is_write_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      error_q, error_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      rsp_ready_q, rsp_ready_d;
    logic                      busy_q, busy_d;
    logic                      b_hs_s, r_hs_s, tmo_hit_s;

    assign b_hs_s = bready_q & m_axi.bvalid;
    assign r_hs_s = rready_q & m_axi.rvalid;

`ifdef REG2AXI_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
    logic        timed_out_q;

    assign tmo_hit_s = ((state_q == ST_WR_RSP) || (state_q == ST_RD_RSP)) &&
                       (tmo_cnt_q == (TIMEOUT_CYCLES - 32'd1));

    // Watchdog counts cycles spent waiting for B/R; timed_out_q steers RESP into DRAIN.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_cnt_q   <= 32'd0;
            timed_out_q <= 1'b0;
        end else begin
            if ((state_q == ST_WR_RSP) || (state_q == ST_RD_RSP)) begin
                tmo_cnt_q <= tmo_cnt_q + 32'd1;
            end else begin
                tmo_cnt_q <= 32'd0;
            end
            if (state_q == ST_IDLE) begin
                timed_out_q <= 1'b0;
            end else if (tmo_hit_s && !b_hs_s && !r_hs_s) begin
                timed_out_q <= 1'b1;
            end else begin
                timed_out_q <= timed_out_q;
            end
        end
    end
`else
    logic unused_s;
    assign tmo_hit_s = 1'b0;
    assign unused_s  = ^{is_write_q, TIMEOUT_CYCLES[0]};
`endif

    logic unused_axi_s;
    assign unused_axi_s = ^{m_axi.bid, m_axi.bresp[0], m_axi.rid, m_axi.rresp[0], m_axi.rlast};

    // Next-state logic; all bus outputs are registered from the next-state values.
    always_comb begin
        state_d    = state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d     = req_addr_i + BASE_ADDR;
                    wdata_d    = req_wdata_i;
                    wstrb_d    = req_wstrb_i;
                    is_write_d = req_write_i;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = req_write_i ? ST_WR_REQ : ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                if (awvalid_q && m_axi.awready) begin
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (wvalid_q && m_axi.wready) begin
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RSP;
                end else begin
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_RSP: begin
                if (b_hs_s) begin
                    error_d = m_axi.bresp[1];
                    rdata_d = {AXI_DATA_WIDTH{1'b0}};
                    state_d = ST_RESP;
                end else if (tmo_hit_s) begin
                    error_d = 1'b1;
                    rdata_d = {AXI_DATA_WIDTH{1'b0}};
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WR_RSP;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_q && m_axi.arready) begin
                    state_d = ST_RD_RSP;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_RSP: begin
                if (r_hs_s) begin
                    error_d = m_axi.rresp[1];
                    rdata_d = m_axi.rdata;
                    state_d = ST_RESP;
                end else if (tmo_hit_s) begin
                    error_d = 1'b1;
                    rdata_d = {AXI_DATA_WIDTH{1'b0}};
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_RD_RSP;
                end
            end
            ST_RESP: begin
`ifdef REG2AXI_TIMEOUT_EN
                state_d = timed_out_q ? ST_DRAIN : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef REG2AXI_TIMEOUT_EN
            // The late response is accepted and thrown away.
            ST_DRAIN: begin
                if (b_hs_s || r_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        awvalid_d   = (state_d == ST_WR_REQ) && !aw_done_d;
        wvalid_d    = (state_d == ST_WR_REQ) && !w_done_d;
        arvalid_d   = (state_d == ST_RD_REQ);
        bready_d    = (state_d == ST_WR_RSP);
        rready_d    = (state_d == ST_RD_RSP);
`ifdef REG2AXI_TIMEOUT_EN
        bready_d    = bready_d || ((state_d == ST_DRAIN) && is_write_d);
        rready_d    = rready_d || ((state_d == ST_DRAIN) && !is_write_d);
`endif
        rsp_ready_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            is_write_q  <= 1'b0;
            addr_q      <= {AXI_ADDR_WIDTH{1'b0}};
            wdata_q     <= {AXI_DATA_WIDTH{1'b0}};
            wstrb_q     <= {AXI_STRB_WIDTH{1'b0}};
            rdata_q     <= {AXI_DATA_WIDTH{1'b0}};
            error_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_ready_q <= rsp_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_rdata_o    = rdata_q;
    assign rsp_error_o    = error_q;
    assign rsp_ready_o    = rsp_ready_q;
    assign busy_o         = busy_q;

    assign m_axi.awid     = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi.awaddr   = addr_q;
    assign m_axi.awlen    = 8'd0;
    assign m_axi.awsize   = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi.awburst  = 2'b01;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = 4'b0010;
    assign m_axi.awprot   = 3'b000;
    assign m_axi.awqos    = 4'd0;
    assign m_axi.awregion = 4'd0;
    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.wdata    = wdata_q;
    assign m_axi.wstrb    = wstrb_q;
    assign m_axi.wlast    = 1'b1;
    assign m_axi.wvalid   = wvalid_q;
    assign m_axi.bready   = bready_q;
    assign m_axi.arid     = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi.araddr   = addr_q;
    assign m_axi.arlen    = 8'd0;
    assign m_axi.arsize   = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi.arburst  = 2'b01;
    assign m_axi.arlock   = 1'b0;
    assign m_axi.arcache  = 4'b0010;
    assign m_axi.arprot   = 3'b000;
    assign m_axi.arqos    = 4'd0;
    assign m_axi.arregion = 4'd0;
    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.rready   = rready_q;
endmodule

// File: tb/tb_custom_reg_to_axi_master.sv
// Directed bench for custom_reg_to_axi_master with a cycle-stepped AXI slave.
module tb_custom_reg_to_axi_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int IW = 2;
    localparam logic [30:0] AX_CONST = {2'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b000, 4'd0, 4'd0};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          req_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_ready;
    logic          busy;

    int check_cnt = 0;
    int err_cnt   = 0;

    custom_reg_to_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .STRB_WIDTH(SW)) axi ();

    custom_reg_to_axi_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_STRB_WIDTH(SW), .AXI_ID_WIDTH(IW),
        .AXI_ID(0), .BASE_ADDR(32'h0400_0000), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata),
        .req_wstrb_i(req_wstrb), .req_valid_i(req_valid),
        .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .rsp_ready_o(rsp_ready),
        .busy_o(busy), .m_axi(axi)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid  = 1'b0; axi.bresp  = 2'b00; axi.bid    = 2'd0;
        axi.rvalid  = 1'b0; axi.rresp  = 2'b00; axi.rid    = 2'd0;
        axi.rdata   = 32'd0; axi.rlast = 1'b0;
    endtask

    // One request; cycle 0 is the cycle whose closing edge first sees req_valid.
    // a_wait = AW (write) or AR (read) ready delay, w_wait = W ready delay,
    // r_wait = cycles between address phase done and B/R valid.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int a_wait, input int w_wait, input int r_wait,
                           input logic [1:0] resp, input logic [31:0] slv_rdata, input int hold_extra,
                           input logic [31:0] exp_axi_addr, input int exp_rsp_cyc,
                           input logic exp_err, input logic [31:0] exp_rdata, input int exp_last_busy);
        int cyc = 0, a_cyc = 0, w_cyc = 0, a_hs = 0, w_hs = 0, resp_cnt = 0;
        int pulses = 0, rsp_cyc = -1, last_busy = 0, busy_cyc = 0, idle_cnt = 0, hold_left;
        logic resp_done = 1'b0;
        logic seen_err = 1'b0;
        logic [31:0] seen_data = 32'd0;
        hold_left = hold_extra;
        @(negedge clk);
        req_addr = addr; req_write = wr; req_wdata = wdata; req_wstrb = strb; req_valid = 1'b1;
        while (cyc < 300 && idle_cnt < 3) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (rsp_ready) begin
                pulses++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc; seen_err = rsp_error; seen_data = rsp_rdata;
                end
            end
            if (pulses > 0 && req_valid) begin
                if (hold_left == 0) req_valid = 1'b0;
                else hold_left--;
            end
            if (busy) begin
                last_busy = cyc; busy_cyc++;
            end
            // response channel first, so an address handshake this cycle counts from the next one
            if (a_hs > 0 && (!wr || w_hs > 0) && !resp_done) begin
                if (resp_cnt >= r_wait) begin
                    if (wr) begin
                        axi.bvalid = 1'b1; axi.bresp = resp;
                        if (axi.bready) resp_done = 1'b1;
                    end else begin
                        axi.rvalid = 1'b1; axi.rresp = resp; axi.rdata = slv_rdata; axi.rlast = 1'b1;
                        if (axi.rready) resp_done = 1'b1;
                    end
                end else begin
                    resp_cnt++;
                end
            end else begin
                axi.bvalid = 1'b0; axi.rvalid = 1'b0;
            end
            if (wr ? axi.awvalid : axi.arvalid) begin
                a_cyc++;
                if (a_cyc == 1) begin
                    if (wr) begin
                        check_eq({tag, ".awaddr"}, axi.awaddr, exp_axi_addr);
                        check_eq({tag, ".awconst"}, {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awlock,
                                 axi.awcache, axi.awprot, axi.awqos, axi.awregion}, AX_CONST);
                    end else begin
                        check_eq({tag, ".araddr"}, axi.araddr, exp_axi_addr);
                        check_eq({tag, ".arconst"}, {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arlock,
                                 axi.arcache, axi.arprot, axi.arqos, axi.arregion}, AX_CONST);
                    end
                end
                if (a_cyc > a_wait) begin
                    a_hs++;
                    if (wr) axi.awready = 1'b1; else axi.arready = 1'b1;
                end else begin
                    axi.awready = 1'b0; axi.arready = 1'b0;
                end
            end else begin
                axi.awready = 1'b0; axi.arready = 1'b0;
            end
            if (axi.wvalid) begin
                w_cyc++;
                if (w_cyc == 1) begin
                    check_eq({tag, ".wdata"}, axi.wdata, wdata);
                    check_eq({tag, ".wstrb_last"}, {axi.wstrb, axi.wlast}, {strb, 1'b1});
                end
                if (w_cyc > w_wait) begin
                    axi.wready = 1'b1; w_hs++;
                end else begin
                    axi.wready = 1'b0;
                end
            end else begin
                axi.wready = 1'b0;
            end
            if (pulses > 0 && resp_done && !req_valid && !busy) idle_cnt++;
        end
        slave_idle();
        req_valid = 1'b0;
        check_eq({tag, ".finished"}, (idle_cnt >= 3), 1'b1);
        check_eq({tag, ".pulses"}, pulses, 1);
        check_eq({tag, ".rsp_cyc"}, rsp_cyc, exp_rsp_cyc);
        check_eq({tag, ".err"}, seen_err, exp_err);
        check_eq({tag, ".rdata"}, seen_data, exp_rdata);
        check_eq({tag, ".rdata_hold"}, rsp_rdata, exp_rdata);
        check_eq({tag, ".a_valid_cycles"}, a_cyc, a_wait + 1);
        check_eq({tag, ".a_handshakes"}, a_hs, 1);
        check_eq({tag, ".w_valid_cycles"}, w_cyc, wr ? (w_wait + 1) : 0);
        check_eq({tag, ".last_busy"}, last_busy, exp_last_busy);
        check_eq({tag, ".busy_cycles"}, busy_cyc, exp_last_busy);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
        slave_idle();
        repeat (3) @(negedge clk);
        check_eq("reset.ctl", {busy, rsp_ready, rsp_error, axi.awvalid, axi.wvalid, axi.arvalid,
                 axi.bready, axi.rready}, 8'h00);
        check_eq("reset.rdata", rsp_rdata, 32'd0);
        check_eq("reset.addr", {axi.awaddr, axi.araddr}, 64'd0);
        check_eq("reset.wdata", {axi.wdata, axi.wstrb}, 36'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //      tag          wr    addr      wdata         strb     aw/ar w  rsp resp   slv_rdata     hold exp_addr        rsp err exp_rdata    busy
        run_txn("wr_zero",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF,    0, 0, 0, 2'b00, 32'h0,        0, 32'h0400_0010, 3, 1'b0, 32'h0,        3);
        run_txn("rd_wait5",  1'b0, 32'h04, 32'h0,        4'h0,    5, 0, 0, 2'b00, 32'h12345678, 0, 32'h0400_0004, 8, 1'b0, 32'h12345678, 8);
        run_txn("wr_w_first",1'b1, 32'h20, 32'hA5A55A5A, 4'b0011, 3, 0, 0, 2'b00, 32'h0,        0, 32'h0400_0020, 6, 1'b0, 32'h0,        6);
        run_txn("wr_aw_first",1'b1,32'h24, 32'h01234567, 4'b1100, 0, 3, 0, 2'b00, 32'h0,        0, 32'h0400_0024, 6, 1'b0, 32'h0,        6);
        run_txn("wr_decerr", 1'b1, 32'h28, 32'h11112222, 4'hF,    0, 0, 0, 2'b11, 32'h0,        0, 32'h0400_0028, 3, 1'b1, 32'h0,        3);
        run_txn("rd_slverr", 1'b0, 32'h2C, 32'h0,        4'h0,    0, 0, 0, 2'b10, 32'hCAFE0001, 0, 32'h0400_002C, 3, 1'b1, 32'hCAFE0001, 3);
        run_txn("rd_okay",   1'b0, 32'h30, 32'h0,        4'h0,    0, 0, 2, 2'b00, 32'h0BADF00D, 0, 32'h0400_0030, 5, 1'b0, 32'h0BADF00D, 5);
        run_txn("rd_exokay", 1'b0, 32'h34, 32'h0,        4'h0,    1, 0, 1, 2'b01, 32'h55AA55AA, 0, 32'h0400_0034, 5, 1'b0, 32'h55AA55AA, 5);
        run_txn("wr_hold",   1'b1, 32'h38, 32'h89ABCDEF, 4'hF,    0, 0, 0, 2'b00, 32'h0,        1, 32'h0400_0038, 3, 1'b0, 32'h0,        3);

        // reset while waiting in WR_RSP
        @(negedge clk);
        req_addr = 32'h40; req_write = 1'b1; req_wdata = 32'h0F0F0F0F; req_wstrb = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        axi.awready = 1'b1; axi.wready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0; axi.wready = 1'b0;
        check_eq("rst_mid.wr_rsp", {axi.bready, busy, axi.awvalid, axi.wvalid}, 4'b1100);
        rst_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid.ctl", {busy, rsp_ready, axi.awvalid, axi.wvalid, axi.arvalid,
                 axi.bready, axi.rready}, 7'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn("rd_post_rst", 1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h76543210, 0, 32'h0400_0044, 3, 1'b0, 32'h76543210, 3);

`ifdef REG2AXI_TIMEOUT_EN
        run_txn("rd_timeout", 1'b0, 32'h48, 32'h0, 4'h0, 0, 0, 40, 2'b00, 32'hFEEDFACE, 0, 32'h0400_0048, 18, 1'b1, 32'h0, 42);
`endif

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule
